// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-port output buffer of the 1x3 router with header-tagged packet drain
//
// Ports:
//   clk, rstn       clock and asynchronous active-low reset
//   soft_rst        synchronous clear (pointers, packet counter, data_out)
//   write_en        write strobe for this port
//   read_en         read strobe from the destination
//   lfd_state       marks the byte on data_in as a packet header
//   data_in         byte to store
//   full, empty     occupancy flags, combinational from the registered pointers
//   data_out        registered read data, forced to zero once a packet is drained

module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             soft_rst,
    input  logic             write_en,
    input  logic             read_en,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    // Each entry is {hdr_flag, byte}.
    logic [WIDTH:0] mem [DEPTH];

    // One extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [6:0]     pkt_cnt;

    logic           do_wr;
    logic           do_rd;
    logic [WIDTH:0] rd_entry;
    logic           rd_hdr;
    logic [6:0]     hdr_len;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});

    // Flags are taken from pre-edge pointers, so a read at full frees a slot
    // only for the next edge and a write at empty is visible only next edge.
    assign do_wr    = write_en && !full;
    assign do_rd    = read_en && !empty;

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign rd_hdr   = rd_entry[WIDTH];

    // Header bits [7:2] carry the payload length; one more covers the parity byte.
    assign hdr_len  = {1'b0, rd_entry[7:2]} + 7'd1;

    // Storage carries no reset; soft_rst only blocks the write in its own edge.
    always_ff @(posedge clk) begin
        if (do_wr && !soft_rst) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt <= '0;
        end else if (soft_rst) begin
            pkt_cnt <= '0;
        end else if (do_rd) begin
            if (rd_hdr) begin
                pkt_cnt <= hdr_len;
            end else if (pkt_cnt != 7'd0) begin
                pkt_cnt <= pkt_cnt - 7'd1;
            end
        end
    end

    // A read always wins; with no read, an exhausted packet count clears the bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out <= '0;
        end else if (soft_rst) begin
            data_out <= '0;
        end else if (do_rd) begin
            data_out <= rd_entry[WIDTH-1:0];
        end else if (pkt_cnt == 7'd0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - self-checking bench for router_fifo

module tb_router_fifo;

    logic       clk;
    logic       rstn;
    logic       soft_rst;
    logic       write_en;
    logic       read_en;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int total;
    int bad;

    // Reference model: queue of {hdr, byte}, plus expected counter and output.
    logic [8:0] mq[$];
    logic [6:0] m_pkt;
    logic [7:0] m_dout;

    typedef struct {
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic [6:0] exp_pkt;
        logic       exp_empty;
    } vec_t;

    vec_t tbl[11];

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .soft_rst  (soft_rst),
        .write_en  (write_en),
        .read_en   (read_en),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .full      (full),
        .empty     (empty),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pkt  = '0;
        m_dout = '0;
    endtask

    // One clock: drive inputs, advance the model with pre-edge occupancy,
    // then compare every output #1 after the edge.
    task automatic cycle(input logic we, input logic re, input logic lfd,
                         input logic [7:0] din, input logic srst);
        logic       m_full;
        logic       m_empty;
        logic       rd_ok;
        logic       wr_ok;
        logic [8:0] e;
        write_en  = we;
        read_en   = re;
        lfd_state = lfd;
        data_in   = din;
        soft_rst  = srst;
        m_full  = (mq.size() == 16);
        m_empty = (mq.size() == 0);
        rd_ok   = re && !m_empty;
        wr_ok   = we && !m_full;
        @(posedge clk);
        #1;
        if (srst) begin
            model_reset();
        end else begin
            if (rd_ok) begin
                e = mq.pop_front();
                m_dout = e[7:0];
                if (e[8]) begin
                    m_pkt = {1'b0, e[7:2]} + 7'd1;
                end else if (m_pkt != 0) begin
                    m_pkt = m_pkt - 7'd1;
                end
            end else if (m_pkt == 0) begin
                m_dout = '0;
            end
            if (wr_ok) begin
                mq.push_back({lfd, din});
            end
        end
        chk("sb_data_out", {24'd0, data_out}, {24'd0, m_dout});
        chk("sb_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("sb_full", {31'd0, full}, {31'd0, mq.size() == 16});
        chk("sb_pkt_cnt", {25'd0, dut.pkt_cnt}, {25'd0, m_pkt});
        write_en = 1'b0;
        read_en  = 1'b0;
        lfd_state = 1'b0;
        soft_rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rstn = 1'b0;
        soft_rst = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
        lfd_state = 1'b0;
        data_in = '0;

        // Packet drain vectors: header 0C (length 3), three payload bytes, parity.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h0C, 8'h00, 7'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 8'h00, 7'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'hA2, 8'h00, 7'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'hA3, 8'h00, 7'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 7'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0C, 7'd4, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 7'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 7'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 7'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 7'd0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 7'd0, 1'b1};

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_dout", {24'd0, data_out}, 32'd0);
        rstn = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("rd_empty_empty", {31'd0, empty}, 32'd1);
        chk("rd_empty_dout", {24'd0, data_out}, 32'd0);

        // 2. fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i), 1'b0);
            chk("fill_full", {31'd0, full}, {31'd0, i == 15});
        end
        cycle(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        chk("overflow_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("drain_data", {24'd0, data_out}, {24'd0, 8'h10 + 8'(i)});
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // 3. packet drain from the vector table
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].we, tbl[i].re, tbl[i].lfd, tbl[i].din, 1'b0);
            chk("tbl_dout", {24'd0, data_out}, {24'd0, tbl[i].exp_dout});
            chk("tbl_pkt", {25'd0, dut.pkt_cnt}, {25'd0, tbl[i].exp_pkt});
            chk("tbl_empty", {31'd0, empty}, {31'd0, tbl[i].exp_empty});
        end

        // 4. concurrent access at full
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i), 1'b0);
        end
        chk("conc_full0", {31'd0, full}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("conc_rd0", {24'd0, data_out}, 32'h30);
        chk("conc_full1", {31'd0, full}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("conc_rd1", {24'd0, data_out}, 32'h31);
        chk("conc_full2", {31'd0, full}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("conc_drain", {24'd0, data_out}, (i == 14) ? 32'h77 : {24'd0, 8'h32 + 8'(i)});
        end
        chk("conc_empty", {31'd0, empty}, 32'd1);

        // 5. soft reset mid-packet
        cycle(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'hB1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'hB2, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("srst_pre_dout", {24'd0, data_out}, 32'h0C);
        cycle(1'b1, 1'b0, 1'b0, 8'h99, 1'b1);
        chk("srst_empty", {31'd0, empty}, 32'd1);
        chk("srst_dout", {24'd0, data_out}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 8'h08, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("srst_hdr_dout", {24'd0, data_out}, 32'h08);
        chk("srst_hdr_pkt", {25'd0, dut.pkt_cnt}, 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("srst_hold_dout", {24'd0, data_out}, 32'h08);

        // 6. asynchronous reset while full, mid-packet
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("arst_pre_dout", {24'd0, data_out}, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 8'hEE, 1'b0);
        chk("arst_pre_full", {31'd0, full}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_full", {31'd0, full}, 32'd0);
        chk("arst_dout", {24'd0, data_out}, 32'd0);
        #1;
        rstn = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h5C, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_arst_rd", {24'd0, data_out}, 32'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
